instr_encoder: RTL

Streaming MIPS instruction encoder. It accepts one instruction per handshake as a kind code plus operand fields, and assembles the 32-bit machine word using the same opcode map the core's main decoder consumes. It emits the word with a sequential word address on a valid/ready output port. It sits in front of the instruction-memory loader and self-check benches, so that programs are generated on-chip instead of from hex files.

---
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bus for instr_encoder.
// The master side issues instruction requests and consumes encoded words.
// The slave side is the encoder itself.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] addr;

  modport master (
    output in_valid, kind, rs, rt, rd, shamt, funct, imm, target, out_ready,
    input  in_ready, out_valid, instr, addr
  );

  modport slave (
    input  in_valid, kind, rs, rt, rd, shamt, funct, imm, target, out_ready,
    output in_ready, out_valid, instr, addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder.
// Accepts one instruction request per handshake, assembles the 32-bit
// machine word and presents it with a sequential word address. After DEPTH
// words the encoder parks in DONE until clear or reset.
// Optional feature macro: INSTR_ENCODER_PAD_EN inserts a NOP delay slot
// after every J/BEQ word (except when the branch used the last address).
module instr_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  instr_encoder_if.slave       bus,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_DONE  = 2'd2
`ifdef INSTR_ENCODER_PAD_EN
    , S_PAD = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              err_q,   err_d;
  logic [7:0]        cnt_q,   cnt_d;
`ifdef INSTR_ENCODER_PAD_EN
  logic              br_q,    br_d;
  logic              is_br;
`endif

  logic              accept;
  logic              out_hs;
  logic              kind_ok;
  logic              last;
  logic              in_ready_c;
  logic              out_valid_c;
  logic [31:0]       enc_word;

  // Assemble the machine word from kind and operand fields; imm is verbatim.
  function automatic logic [31:0] encode(
    input logic [3:0]  k,
    input logic [4:0]  rs_f,
    input logic [4:0]  rt_f,
    input logic [4:0]  rd_f,
    input logic [4:0]  sh_f,
    input logic [5:0]  fn_f,
    input logic [15:0] im_f,
    input logic [25:0] tg_f
  );
    logic [5:0] op;
    logic [4:0] rs_eff;
    op = 6'b000000;
    case (k)
      4'd0:    op = 6'b000000;
      4'd1:    op = 6'b000010;
      4'd2:    op = 6'b000100;
      4'd3:    op = 6'b001000;
      4'd4:    op = 6'b001001;
      4'd5:    op = 6'b001010;
      4'd6:    op = 6'b001100;
      4'd7:    op = 6'b001101;
      4'd8:    op = 6'b001110;
      4'd9:    op = 6'b001111;
      4'd10:   op = 6'b100011;
      4'd11:   op = 6'b101011;
      default: op = 6'b000000;
    endcase
    // LUI has no source register; the field is forced to zero.
    rs_eff = (k == 4'd9) ? 5'd0 : rs_f;
    if (k == 4'd0)
      encode = {op, rs_f, rt_f, rd_f, sh_f, fn_f};
    else if (k == 4'd1)
      encode = {op, tg_f};
    else
      encode = {op, rs_eff, rt_f, im_f};
  endfunction

  assign kind_ok  = (bus.kind <= 4'd11);
  assign last     = (addr_q == ADDR_W'(DEPTH - 1));
  assign enc_word = encode(bus.kind, bus.rs, bus.rt, bus.rd, bus.shamt,
                           bus.funct, bus.imm, bus.target);
  assign accept   = bus.in_valid && in_ready_c;
  assign out_hs   = out_valid_c && bus.out_ready;
`ifdef INSTR_ENCODER_PAD_EN
  assign is_br    = (bus.kind == 4'd1) || (bus.kind == 4'd2);
`endif

  // Handshake qualifiers depend only on the state register and out_ready.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      S_EMPTY: in_ready_c = 1'b1;
      S_HOLD: begin
        out_valid_c = 1'b1;
`ifdef INSTR_ENCODER_PAD_EN
        // A held branch is followed by its pad, so no new request overlaps it.
        in_ready_c  = bus.out_ready && !br_q;
`else
        in_ready_c  = bus.out_ready;
`endif
      end
`ifdef INSTR_ENCODER_PAD_EN
      S_PAD:   out_valid_c = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next-state, output word, address and error bookkeeping.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef INSTR_ENCODER_PAD_EN
    br_d    = br_q;
`endif
    if (clear) begin
      state_d = S_EMPTY;
      addr_d  = '0;
      err_d   = 1'b0;
      cnt_d   = 8'd0;
    end else begin
      if (accept && !kind_ok) begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
      case (state_q)
        S_EMPTY: begin
          if (accept && kind_ok) begin
            state_d = S_HOLD;
            instr_d = enc_word;
`ifdef INSTR_ENCODER_PAD_EN
            br_d    = is_br;
`endif
          end
        end
        S_HOLD: begin
          if (out_hs) begin
            addr_d = addr_q + 1'b1;
            if (last) begin
              state_d = S_DONE;
            end
`ifdef INSTR_ENCODER_PAD_EN
            else if (br_q) begin
              state_d = S_PAD;
              instr_d = 32'h0000_0000;
            end
`endif
            else if (accept && kind_ok) begin
              instr_d = enc_word;
`ifdef INSTR_ENCODER_PAD_EN
              br_d    = is_br;
`endif
            end else begin
              state_d = S_EMPTY;
            end
          end
        end
`ifdef INSTR_ENCODER_PAD_EN
        S_PAD: begin
          if (out_hs) begin
            addr_d  = addr_q + 1'b1;
            state_d = last ? S_DONE : S_EMPTY;
            br_d    = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State and output registers; reset discards any held word immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      instr_q <= 32'h0000_0000;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef INSTR_ENCODER_PAD_EN
      br_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef INSTR_ENCODER_PAD_EN
      br_q    <= br_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.instr     = instr_q;
  assign bus.addr      = addr_q;
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign err_cnt       = cnt_q;

endmodule
